processor_sequencer: RTL

PROCESSOR_SEQUENCER -- requirements
Module: processor_sequencer

---
 rtl/processor_seq_pkg.sv | 17 +
 rtl/instr_counter.sv | 24 ++
 rtl/processor_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/processor_seq_pkg.sv
// rtl/processor_seq_pkg.sv - shared state encodings and opcode defaults for the sequencer
package processor_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } seq_state_t;

  localparam logic [4:0] HALT_OPCODE_DEFAULT = 5'h1F;
  localparam logic [4:0] NOP_OPCODE_DEFAULT  = 5'h00;
  localparam int         COUNT_WIDTH         = 16;

endpackage

// File: rtl/instr_counter.sv
// rtl/instr_counter.sv - saturating retired-instruction counter
module instr_counter
  import processor_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] count_q;

  // Holds at all-ones so a long run never wraps back to a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/processor_sequencer.sv
// rtl/processor_sequencer.sv - fetch/decode/execute/writeback control FSM with single-step debug
module processor_sequencer
  import processor_seq_pkg::*;
#(
  parameter logic [4:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter logic [4:0] NOP_OPCODE  = NOP_OPCODE_DEFAULT
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_start,
  input  logic [4:0]  in_op_code,
  input  logic        in_pm_ready,
  input  logic        in_step_en,
  input  logic        in_step,
  output logic        out_pc_en,
  output logic        out_ir_load,
  output logic        out_alu_result_load,
  output logic        out_rf_wr_en,
  output logic        out_busy,
  output logic        out_halted,
  output logic [2:0]  out_state,
  output logic [15:0] out_instr_count
);

  seq_state_t state;
  logic [4:0] opcode;
  logic       step_latch;
  logic       fetch_adv;
  logic       retire;

  // Step mode gates only the FETCH hand-off, so toggling in_step_en mid-instruction
  // has no effect until the sequencer comes back around to FETCH.
  assign fetch_adv = (state == ST_FETCH) && in_pm_ready && (!in_step_en || step_latch);
  assign retire    = (state == ST_WRITEBACK);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state      <= ST_IDLE;
      opcode     <= '0;
      step_latch <= 1'b0;
    end else begin
      // Clearing wins over a simultaneous step request.
      if (fetch_adv) begin
        step_latch <= 1'b0;
      end else if (in_step && in_step_en) begin
        step_latch <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (in_start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (fetch_adv) state <= ST_DECODE;
        end
        ST_DECODE: begin
          opcode <= in_op_code;
          state  <= (in_op_code == HALT_OPCODE) ? ST_HALT : ST_EXECUTE;
        end
        ST_EXECUTE: begin
          state <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          state <= ST_FETCH;
        end
        ST_HALT: begin
          if (in_start) state <= ST_FETCH;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  instr_counter u_counter (
    .clk   (in_clk),
    .rst   (in_rst),
    .inc   (retire),
    .count (out_instr_count)
  );

  // Enables decode straight from the state register, so reset clears them at once.
  assign out_pc_en           = fetch_adv;
  assign out_ir_load         = fetch_adv;
  assign out_alu_result_load = (state == ST_EXECUTE);
  assign out_rf_wr_en        = retire && (opcode != NOP_OPCODE);
  assign out_busy            = (state == ST_FETCH) || (state == ST_DECODE) ||
                               (state == ST_EXECUTE) || (state == ST_WRITEBACK);
  assign out_halted          = (state == ST_HALT);
  assign out_state           = state;

endmodule
